absorb_sequencer: RTL and testbench

Upstream feeder for padding_generator. It accepts a byte-length-tagged message as a stream of w-bit words and re-emits it as rate-aligned words. It drives the padding_generator control inputs (remaining_valid_bytes, padding_enable, last_word_in_block, padding_reset), so the generator's data_o carries a correctly SHAKE-padded sequence of rate blocks to the absorb stage.

---
 rtl/absorb_sequencer_if.sv | 39 +++
 rtl/absorb_sequencer.sv | 138 +++++++++++++
 tb/tb_absorb_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/absorb_sequencer_if.sv
// Handshake and control bundle between a message source, the absorb sequencer
// and the downstream padding generator.
interface absorb_sequencer_if #(
  parameter int W     = 64,
  parameter int LEN_W = 32,
  parameter int RVB_W = $clog2(W / 8) + 1
);
  logic             start_i;
  logic [LEN_W-1:0] msg_len_i;
  logic             busy_o;
  logic             done_o;
  logic [W-1:0]     in_data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [W-1:0]     out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [RVB_W-1:0] remaining_valid_bytes_o;
  logic             padding_enable_o;
  logic             last_word_in_block_o;
  logic             padding_reset_o;
  logic             block_done_o;

  // Sequencer side
  modport slave (
    input  start_i, msg_len_i, in_data_i, in_valid_i, out_ready_i,
    output busy_o, done_o, in_ready_o, out_data_o, out_valid_o,
           remaining_valid_bytes_o, padding_enable_o, last_word_in_block_o,
           padding_reset_o, block_done_o
  );

  // Source / sink side
  modport master (
    output start_i, msg_len_i, in_data_i, in_valid_i, out_ready_i,
    input  busy_o, done_o, in_ready_o, out_data_o, out_valid_o,
           remaining_valid_bytes_o, padding_enable_o, last_word_in_block_o,
           padding_reset_o, block_done_o
  );
endinterface

// File: rtl/absorb_sequencer.sv
// Re-emits a byte-length-tagged message as rate-aligned words and drives the
// padding generator controls so its output is a SHAKE-padded block sequence.
module absorb_sequencer #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 21,
  parameter int LEN_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  absorb_sequencer_if.slave bus
);
  localparam int BYTES = W / 8;
  localparam int RVB_W = $clog2(BYTES) + 1;
  localparam int CNT_W = $clog2(RATE_WORDS + 1);

  localparam logic [LEN_W-1:0] BYTES_L   = LEN_W'(BYTES);
  localparam logic [LEN_W-1:0] TWO_WORDS = LEN_W'(2 * BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RATE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MSG  = 3'd1,
    S_TAIL = 3'd2,
    S_ZERO = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_accept;
  logic             w_fire;
  logic             w_last_cnt;
  logic             w_pad_state;
  logic [W-1:0]     w_out_data;
  logic             w_out_valid;
  logic             w_in_ready;
  logic [RVB_W-1:0] w_rvb;
  logic             w_done;
  logic             w_pad_reset;

  assign w_last_cnt  = (r_word_cnt == LAST_CNT);
  assign w_pad_state = (r_state == S_TAIL) || (r_state == S_ZERO);
  assign w_accept    = (r_state == S_IDLE) && bus.start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rem      <= bus.msg_len_i;
        r_word_cnt <= '0;
      end else if (w_fire) begin
        if (r_state == S_MSG) begin
          r_rem <= r_rem - BYTES_L;
        end
        r_word_cnt <= w_last_cnt ? '0 : r_word_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_data  = '0;
    w_out_valid = 1'b0;
    w_in_ready  = 1'b0;
    w_rvb       = '0;
    w_done      = 1'b0;
    w_pad_reset = 1'b0;
    w_fire      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_pad_reset = 1'b1;
          w_state_nxt = (bus.msg_len_i >= BYTES_L) ? S_MSG : S_TAIL;
        end
      end
      S_MSG: begin
        w_out_data  = bus.in_data_i;
        w_out_valid = bus.in_valid_i;
        w_in_ready  = bus.out_ready_i;
        w_rvb       = RVB_W'(BYTES);
        w_fire      = w_out_valid & bus.out_ready_i;
        // Leaving MSG once fewer than one full word of bytes would remain.
        if (w_fire && (r_rem < TWO_WORDS)) begin
          w_state_nxt = S_TAIL;
        end
      end
      S_TAIL: begin
        w_rvb = RVB_W'(r_rem);
        if (r_rem != '0) begin
          w_out_data  = bus.in_data_i;
          w_out_valid = bus.in_valid_i;
          w_in_ready  = bus.out_ready_i;
        end else begin
          w_out_valid = 1'b1;
        end
        w_fire = w_out_valid & bus.out_ready_i;
        if (w_fire) begin
          w_state_nxt = w_last_cnt ? S_DONE : S_ZERO;
        end
      end
      S_ZERO: begin
        w_out_valid = 1'b1;
        w_fire      = bus.out_ready_i;
        if (w_fire && w_last_cnt) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o                  = (r_state != S_IDLE);
  assign bus.done_o                  = w_done;
  assign bus.in_ready_o              = w_in_ready;
  assign bus.out_data_o              = w_out_data;
  assign bus.out_valid_o             = w_out_valid;
  assign bus.remaining_valid_bytes_o = w_rvb;
  // Gated by fire so the generator's separator latch is never set by a stalled word.
  assign bus.padding_enable_o        = w_fire & w_pad_state;
  assign bus.last_word_in_block_o    = w_pad_state & w_last_cnt;
  assign bus.padding_reset_o         = w_pad_reset;
  assign bus.block_done_o            = w_fire & w_last_cnt;

endmodule

// File: tb/tb_absorb_sequencer.sv
// Directed bench for absorb_sequencer: several message lengths, a stalled
// tail word, and an asynchronous reset in mid-message.
module tb_absorb_sequencer;
  localparam int W     = 64;
  localparam int RW    = 21;
  localparam int LEN_W = 32;
  localparam int MAXW  = 64;

  logic clk;
  logic rst_n;

  absorb_sequencer_if #(.W(W), .LEN_W(LEN_W)) bus ();

  absorb_sequencer #(.W(W), .RATE_WORDS(RW), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Observations of the most recent run
  int         nwords, ninputs, npe, nbd, ndone, nstall;
  int         fire_cyc, done_cyc;
  bit         padrst_seen, stall_pe, stall_inr, aborted;
  logic [3:0] o_rvb  [MAXW];
  bit         o_pe   [MAXW];
  bit         o_last [MAXW];
  bit         o_bd   [MAXW];
  logic [W-1:0] o_data [MAXW];

  function automatic logic [W-1:0] pat(input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return {16'hC0DE, kk, 32'h0BAD_F00D};
  endfunction

  // Drives one message and records every output fire.
  task automatic run_msg(input int len, input int stall_at, input int stall_n,
                         input int abort_at, input int poke_at);
    int in_idx;
    int stalled;
    int cyc;
    bit done_seen;
    nwords = 0; ninputs = 0; npe = 0; nbd = 0; ndone = 0; nstall = 0;
    fire_cyc = -1; done_cyc = -1;
    padrst_seen = 0; stall_pe = 0; stall_inr = 0; aborted = 0;
    in_idx = 0; stalled = 0; cyc = 0; done_seen = 0;
    for (int i = 0; i < MAXW; i++) begin
      o_rvb[i] = '0; o_pe[i] = 0; o_last[i] = 0; o_bd[i] = 0; o_data[i] = '0;
    end

    @(posedge clk); #1;
    bus.start_i     = 1'b1;
    bus.msg_len_i   = LEN_W'(len);
    bus.in_data_i   = pat(0);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    padrst_seen = bus.padding_reset_o;
    @(posedge clk); #1;
    bus.start_i = 1'b0;

    while (!done_seen && cyc < 400) begin
      if (abort_at >= 0 && nwords == abort_at) begin
        aborted = 1;
        break;
      end
      if (nwords == stall_at && stalled < stall_n) begin
        bus.out_ready_i = 1'b0;
        stalled++;
      end else begin
        bus.out_ready_i = 1'b1;
      end
      bus.in_data_i = pat(in_idx);
      if (cyc == poke_at) begin
        bus.start_i   = 1'b1;
        bus.msg_len_i = LEN_W'(77);
      end

      @(negedge clk);
      if (bus.out_valid_o && !bus.out_ready_i) begin
        nstall++;
        stall_pe  |= bus.padding_enable_o;
        stall_inr |= bus.in_ready_o;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        ninputs++;
        in_idx++;
      end
      if (bus.padding_enable_o) npe++;
      if (bus.block_done_o) nbd++;
      if (bus.done_o) begin
        ndone++;
        done_cyc  = cyc;
        done_seen = 1;
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (nwords < MAXW) begin
          o_rvb[nwords]  = bus.remaining_valid_bytes_o;
          o_pe[nwords]   = bus.padding_enable_o;
          o_last[nwords] = bus.last_word_in_block_o;
          o_bd[nwords]   = bus.block_done_o;
          o_data[nwords] = bus.out_data_o;
        end
        nwords++;
        fire_cyc = cyc;
      end

      @(posedge clk); #1;
      bus.start_i = 1'b0;
      cyc++;
    end

    n_cmp++;
    if (!done_seen && !aborted) begin
      n_fail++;
      $display("FAIL run_timeout len=%0d got no done after %0d cycles, want done", len, cyc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.msg_len_i = '0; bus.in_data_i = '0;
    bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    #12;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready_o); end
    n_cmp++; if ({bus.done_o, bus.padding_enable_o, bus.last_word_in_block_o, bus.padding_reset_o, bus.block_done_o} !== 5'b0) begin
      n_fail++; $display("FAIL rst_ctrl got %b want 00000",
        {bus.done_o, bus.padding_enable_o, bus.last_word_in_block_o, bus.padding_reset_o, bus.block_done_o});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_len0;
    run_msg(0, -1, 0, -1, -1);
    n_cmp++; if (padrst_seen !== 1'b1) begin n_fail++; $display("FAIL len0_padrst got %b want 1", padrst_seen); end
    n_cmp++; if (nwords !== 21) begin n_fail++; $display("FAIL len0_words got %0d want 21", nwords); end
    n_cmp++; if (ninputs !== 0) begin n_fail++; $display("FAIL len0_inputs got %0d want 0", ninputs); end
    n_cmp++; if (o_rvb[0] !== 4'd0) begin n_fail++; $display("FAIL len0_rvb0 got %0d want 0", o_rvb[0]); end
    n_cmp++; if (o_pe[0] !== 1'b1) begin n_fail++; $display("FAIL len0_pe0 got %b want 1", o_pe[0]); end
    n_cmp++; if (o_data[0] !== '0) begin n_fail++; $display("FAIL len0_data0 got %h want 0", o_data[0]); end
    n_cmp++; if (o_last[19] !== 1'b0) begin n_fail++; $display("FAIL len0_last19 got %b want 0", o_last[19]); end
    n_cmp++; if (o_last[20] !== 1'b1) begin n_fail++; $display("FAIL len0_last20 got %b want 1", o_last[20]); end
    n_cmp++; if (npe !== 21) begin n_fail++; $display("FAIL len0_pe_count got %0d want 21", npe); end
    n_cmp++; if (nbd !== 1 || o_bd[20] !== 1'b1) begin n_fail++; $display("FAIL len0_block_done got %0d/%b want 1/1", nbd, o_bd[20]); end
    n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL len0_done got %0d want 1", ndone); end
  endtask

  task automatic test_len13;
    run_msg(13, -1, 0, -1, -1);
    n_cmp++; if (nwords !== 21) begin n_fail++; $display("FAIL len13_words got %0d want 21", nwords); end
    n_cmp++; if (ninputs !== 2) begin n_fail++; $display("FAIL len13_inputs got %0d want 2", ninputs); end
    n_cmp++; if (o_rvb[0] !== 4'd8 || o_pe[0] !== 1'b0) begin n_fail++; $display("FAIL len13_w0 got rvb=%0d pe=%b want 8/0", o_rvb[0], o_pe[0]); end
    n_cmp++; if (o_rvb[1] !== 4'd5 || o_pe[1] !== 1'b1) begin n_fail++; $display("FAIL len13_w1 got rvb=%0d pe=%b want 5/1", o_rvb[1], o_pe[1]); end
    n_cmp++; if (o_data[0] !== pat(0)) begin n_fail++; $display("FAIL len13_data0 got %h want %h", o_data[0], pat(0)); end
    n_cmp++; if (o_data[1] !== pat(1)) begin n_fail++; $display("FAIL len13_data1 got %h want %h", o_data[1], pat(1)); end
    n_cmp++; if (o_data[2] !== '0 || o_rvb[2] !== 4'd0) begin n_fail++; $display("FAIL len13_zero2 got %h/%0d want 0/0", o_data[2], o_rvb[2]); end
    n_cmp++; if (npe !== 20) begin n_fail++; $display("FAIL len13_pe_count got %0d want 20", npe); end
    n_cmp++; if (o_last[20] !== 1'b1) begin n_fail++; $display("FAIL len13_last20 got %b want 1", o_last[20]); end
  endtask

  task automatic test_len167;
    run_msg(167, -1, 0, -1, -1);
    n_cmp++; if (nwords !== 21) begin n_fail++; $display("FAIL len167_words got %0d want 21", nwords); end
    n_cmp++; if (ninputs !== 21) begin n_fail++; $display("FAIL len167_inputs got %0d want 21", ninputs); end
    n_cmp++; if (o_rvb[19] !== 4'd8 || o_last[19] !== 1'b0) begin n_fail++; $display("FAIL len167_w19 got rvb=%0d last=%b want 8/0", o_rvb[19], o_last[19]); end
    n_cmp++; if (o_rvb[20] !== 4'd7 || o_last[20] !== 1'b1 || o_pe[20] !== 1'b1) begin
      n_fail++; $display("FAIL len167_w20 got rvb=%0d last=%b pe=%b want 7/1/1", o_rvb[20], o_last[20], o_pe[20]);
    end
    n_cmp++; if (npe !== 1) begin n_fail++; $display("FAIL len167_pe_count got %0d want 1", npe); end
    n_cmp++; if ((done_cyc - fire_cyc) < 1 || (done_cyc - fire_cyc) > 2) begin
      n_fail++; $display("FAIL len167_done_lat got %0d cycles want 1..2", done_cyc - fire_cyc);
    end
  endtask

  task automatic test_len168;
    run_msg(168, -1, 0, -1, -1);
    n_cmp++; if (nwords !== 42) begin n_fail++; $display("FAIL len168_words got %0d want 42", nwords); end
    n_cmp++; if (ninputs !== 21) begin n_fail++; $display("FAIL len168_inputs got %0d want 21", ninputs); end
    n_cmp++; if (o_bd[20] !== 1'b1 || o_rvb[20] !== 4'd8 || o_last[20] !== 1'b0) begin
      n_fail++; $display("FAIL len168_w20 got bd=%b rvb=%0d last=%b want 1/8/0", o_bd[20], o_rvb[20], o_last[20]);
    end
    n_cmp++; if (o_rvb[21] !== 4'd0 || o_pe[21] !== 1'b1 || o_data[21] !== '0) begin
      n_fail++; $display("FAIL len168_w21 got rvb=%0d pe=%b data=%h want 0/1/0", o_rvb[21], o_pe[21], o_data[21]);
    end
    n_cmp++; if (o_last[41] !== 1'b1 || o_bd[41] !== 1'b1) begin n_fail++; $display("FAIL len168_w41 got last=%b bd=%b want 1/1", o_last[41], o_bd[41]); end
    n_cmp++; if (nbd !== 2) begin n_fail++; $display("FAIL len168_bd_count got %0d want 2", nbd); end
    n_cmp++; if (o_data[20] !== pat(20)) begin n_fail++; $display("FAIL len168_data20 got %h want %h", o_data[20], pat(20)); end
  endtask

  task automatic test_stall_tail;
    run_msg(13, 1, 5, -1, -1);
    n_cmp++; if (nstall !== 5) begin n_fail++; $display("FAIL stall_cycles got %0d want 5", nstall); end
    n_cmp++; if (stall_pe !== 1'b0) begin n_fail++; $display("FAIL stall_pe got %b want 0", stall_pe); end
    n_cmp++; if (stall_inr !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", stall_inr); end
    n_cmp++; if (o_pe[1] !== 1'b1 || o_rvb[1] !== 4'd5 || o_data[1] !== pat(1)) begin
      n_fail++; $display("FAIL stall_w1 got pe=%b rvb=%0d data=%h want 1/5/%h", o_pe[1], o_rvb[1], o_data[1], pat(1));
    end
    n_cmp++; if (nwords !== 21 || ninputs !== 2 || npe !== 20) begin
      n_fail++; $display("FAIL stall_totals got %0d/%0d/%0d want 21/2/20", nwords, ninputs, npe);
    end
  endtask

  task automatic test_reset_mid;
    run_msg(100, -1, 0, 10, -1);
    n_cmp++; if (aborted !== 1'b1 || bus.busy_o !== 1'b1 || bus.out_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got abort=%b busy=%b valid=%b want 1/1/1", aborted, bus.busy_o, bus.out_valid_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.busy_o, bus.out_valid_o, bus.in_ready_o, bus.done_o, bus.padding_enable_o,
                 bus.last_word_in_block_o, bus.padding_reset_o, bus.block_done_o} !== 8'b0) begin
      n_fail++; $display("FAIL mid_rst_outputs got %b want 00000000",
        {bus.busy_o, bus.out_valid_o, bus.in_ready_o, bus.done_o, bus.padding_enable_o,
         bus.last_word_in_block_o, bus.padding_reset_o, bus.block_done_o});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_rst got valid=%b busy=%b want 0/0", bus.out_valid_o, bus.busy_o);
    end
    run_msg(5, -1, 0, -1, 3);
    n_cmp++; if (padrst_seen !== 1'b1) begin n_fail++; $display("FAIL len5_padrst got %b want 1", padrst_seen); end
    n_cmp++; if (nwords !== 21 || ninputs !== 1) begin n_fail++; $display("FAIL len5_totals got %0d/%0d want 21/1", nwords, ninputs); end
    n_cmp++; if (o_rvb[0] !== 4'd5 || o_pe[0] !== 1'b1 || o_data[0] !== pat(0)) begin
      n_fail++; $display("FAIL len5_w0 got rvb=%0d pe=%b data=%h want 5/1/%h", o_rvb[0], o_pe[0], o_data[0], pat(0));
    end
    n_cmp++; if (o_last[20] !== 1'b1 || ndone !== 1) begin n_fail++; $display("FAIL len5_end got last=%b done=%0d want 1/1", o_last[20], ndone); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL len5_poke_ignored got busy=%b want 0", bus.busy_o); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_len0();
    test_len13();
    test_len167();
    test_len168();
    test_stall_tail();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
